// File: rtl/fsm_branch_pkg.sv
// fsm_branch_pkg: state codes and y1/y2 decode for fsm_branch_timed.
// Shared by the FSM top and its arm timer.
package fsm_branch_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARM_P  = 3'd1,
      LOCK_T = 3'd2,
      ARM_R  = 3'd3,
      LOCK_V = 3'd4,
      ABORT  = 3'd5
   } state_t;

   localparam logic [2:0] C_IDLE   = 3'd0;
   localparam logic [2:0] C_ARM_P  = 3'd1;
   localparam logic [2:0] C_LOCK_T = 3'd2;
   localparam logic [2:0] C_ARM_R  = 3'd3;
   localparam logic [2:0] C_LOCK_V = 3'd4;
   localparam logic [2:0] C_ABORT  = 3'd5;

   typedef struct packed {
      logic y1;
      logic y2;
   } yout_t;

   localparam yout_t Y_P_SIDE = '{y1: 1'b1, y2: 1'b0};
   localparam yout_t Y_R_SIDE = '{y1: 1'b0, y2: 1'b1};
   localparam yout_t Y_NONE   = '{y1: 1'b0, y2: 1'b0};

   function automatic yout_t decode_y(input logic [2:0] s);
      yout_t r;
      r = Y_NONE;
      unique case (s)
         C_IDLE, C_ARM_P, C_LOCK_T: r = Y_P_SIDE;
         C_ARM_R, C_LOCK_V:         r = Y_R_SIDE;
         default:                   r = Y_NONE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/fsm_branch_timed_arm_timer.sv
// arm_timer: cycles-in-ARM counter with expiry compare.
// Saturates instead of wrapping so TIMEOUT=0 can wait forever.
module arm_timer #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expire
);

   localparam logic [CNT_W-1:0] LAST =
      CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [CNT_W-1:0] MAX = '1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear on ARM entry, else step while staying.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (en && (cnt_q != MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/fsm_branch_timed.sv
// fsm_branch_timed: start-gated two-branch a/b sequence FSM
// with arm timeout. Optional stats ports: FSM_BRANCH_STATS_EN.
module fsm_branch_timed
   import fsm_branch_pkg::*;
#(
   parameter int TIMEOUT    = 16,
   parameter int CNT_W      = 8,
   parameter int AUTO_REARM = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             a,
   input  logic             b,
   input  logic             clr,
   output logic             y1,
   output logic             y2,
   output logic [2:0]       state_o,
   output logic             done,
   output logic             timeout
`ifdef FSM_BRANCH_STATS_EN
   ,
   output logic [CNT_W-1:0] lock_cnt,
   output logic [CNT_W-1:0] abort_cnt
`endif
);

   state_t state_q;
   logic   in_arm;
   logic   confirm;
   logic   expire;
   logic   t_load;
   logic   t_en;
   yout_t  yd;

   // Arm-state qualifiers driving the timer and the FSM.
   always_comb begin
      in_arm  = (state_q == ARM_P) || (state_q == ARM_R);
      confirm = ((state_q == ARM_P) && b) ||
                ((state_q == ARM_R) && a);
      t_load  = (state_q == IDLE) && start && !clr;
      t_en    = in_arm && !confirm && !expire && !clr;
   end

   arm_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_arm_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (t_load),
      .en     (t_en),
      .expire (expire)
   );

   // State register: rst, then clr, then sequence transitions.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else if (clr) begin
         state_q <= IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= a ? ARM_P : ARM_R;
               end
            end
            ARM_P: begin
               if (b) begin
                  state_q <= LOCK_T;
               end else if (expire) begin
                  state_q <= ABORT;
               end
            end
            ARM_R: begin
               if (a) begin
                  state_q <= LOCK_V;
               end else if (expire) begin
                  state_q <= ABORT;
               end
            end
            LOCK_T, LOCK_V, ABORT: begin
               if (AUTO_REARM != 0) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Moore decode straight from the state register.
   always_comb begin
      yd      = decode_y(state_q);
      y1      = yd.y1;
      y2      = yd.y2;
      state_o = state_q;
      done    = (state_q == LOCK_T) || (state_q == LOCK_V);
      timeout = (state_q == ABORT);
   end

`ifdef FSM_BRANCH_STATS_EN
   localparam logic [CNT_W-1:0] CMAX = '1;

   logic lock_ev;
   logic abort_ev;
   logic [CNT_W-1:0] lock_q;
   logic [CNT_W-1:0] abort_q;

   // Entry events, aligned with the transition they count.
   always_comb begin
      lock_ev  = !clr && confirm;
      abort_ev = !clr && in_arm && !confirm && expire;
   end

   // Saturating stats counters; only rst clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q  <= '0;
         abort_q <= '0;
      end else begin
         if (lock_ev && (lock_q != CMAX)) begin
            lock_q <= lock_q + 1'b1;
         end
         if (abort_ev && (abort_q != CMAX)) begin
            abort_q <= abort_q + 1'b1;
         end
      end
   end

   assign lock_cnt  = lock_q;
   assign abort_cnt = abort_q;
`endif

endmodule

// File: tb/tb_fsm_branch_timed.sv
// tb_fsm_branch_timed: directed scoreboard bench, four configs.
// Stats checks run when FSM_BRANCH_STATS_EN is defined.
module tb_fsm_branch_timed;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       st_v [4];
   logic       a_v  [4];
   logic       b_v  [4];
   logic       clr_v[4];
   logic       rst_v[4];
   logic       y1_w [4];
   logic       y2_w [4];
   logic       dn_w [4];
   logic       to_w [4];
   logic [2:0] so_w [4];
`ifdef FSM_BRANCH_STATS_EN
   logic [7:0] lc0, ac0, lc1, ac1, lc2, ac2;
   logic [1:0] lc3, ac3;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         d;
      logic [2:0] s;
      string      tag;
   } exp_t;
   exp_t sbq[$];

   fsm_branch_timed #(.TIMEOUT(4), .CNT_W(8), .AUTO_REARM(0)) u0 (
      .clk(clk), .rst(rst_v[0]), .start(st_v[0]), .a(a_v[0]),
      .b(b_v[0]), .clr(clr_v[0]), .y1(y1_w[0]), .y2(y2_w[0]),
      .state_o(so_w[0]), .done(dn_w[0]), .timeout(to_w[0])
`ifdef FSM_BRANCH_STATS_EN
      , .lock_cnt(lc0), .abort_cnt(ac0)
`endif
   );

   fsm_branch_timed #(.TIMEOUT(4), .CNT_W(8), .AUTO_REARM(1)) u1 (
      .clk(clk), .rst(rst_v[1]), .start(st_v[1]), .a(a_v[1]),
      .b(b_v[1]), .clr(clr_v[1]), .y1(y1_w[1]), .y2(y2_w[1]),
      .state_o(so_w[1]), .done(dn_w[1]), .timeout(to_w[1])
`ifdef FSM_BRANCH_STATS_EN
      , .lock_cnt(lc1), .abort_cnt(ac1)
`endif
   );

   fsm_branch_timed #(.TIMEOUT(0), .CNT_W(8), .AUTO_REARM(0)) u2 (
      .clk(clk), .rst(rst_v[2]), .start(st_v[2]), .a(a_v[2]),
      .b(b_v[2]), .clr(clr_v[2]), .y1(y1_w[2]), .y2(y2_w[2]),
      .state_o(so_w[2]), .done(dn_w[2]), .timeout(to_w[2])
`ifdef FSM_BRANCH_STATS_EN
      , .lock_cnt(lc2), .abort_cnt(ac2)
`endif
   );

   fsm_branch_timed #(.TIMEOUT(3), .CNT_W(2), .AUTO_REARM(1)) u3 (
      .clk(clk), .rst(rst_v[3]), .start(st_v[3]), .a(a_v[3]),
      .b(b_v[3]), .clr(clr_v[3]), .y1(y1_w[3]), .y2(y2_w[3]),
      .state_o(so_w[3]), .done(dn_w[3]), .timeout(to_w[3])
`ifdef FSM_BRANCH_STATS_EN
      , .lock_cnt(lc3), .abort_cnt(ac3)
`endif
   );

   // {state, y1, y2, done, timeout} expected for a state code
   function automatic logic [6:0] model(input logic [2:0] s);
      logic [3:0] o;
      case (s)
         3'd0:    o = 4'b1000;
         3'd1:    o = 4'b1000;
         3'd2:    o = 4'b1010;
         3'd3:    o = 4'b0100;
         3'd4:    o = 4'b0110;
         3'd5:    o = 4'b0001;
         default: o = 4'b0000;
      endcase
      return {s, o};
   endfunction

   function automatic logic [6:0] obs(input int d);
      return {so_w[d], y1_w[d], y2_w[d], dn_w[d], to_w[d]};
   endfunction

   task automatic check_out();
      exp_t e;
      logic [6:0] o;
      logic [6:0] x;
      checks++;
      if (sbq.size() == 0) begin
         failures++;
         $error("FAIL sb_empty: no expected entry");
         return;
      end
      e = sbq.pop_front();
      o = obs(e.d);
      x = model(e.s);
      assert (o === x) else begin
         failures++;
         $error("FAIL %s dut%0d: got %b want %b",
                e.tag, e.d, o, x);
      end
   endtask

   // Drive one cycle of inputs on DUT d, then check after the edge.
   task automatic cyc(input int d, input logic s_i, input logic a_i,
                      input logic b_i, input logic c_i,
                      input logic r_i, input logic [2:0] es,
                      input string tag);
      exp_t e;
      st_v[d]  = s_i;
      a_v[d]   = a_i;
      b_v[d]   = b_i;
      clr_v[d] = c_i;
      rst_v[d] = r_i;
      e.d = d;
      e.s = es;
      e.tag = tag;
      sbq.push_back(e);
      @(posedge clk);
      @(negedge clk);
      check_out();
   endtask

`ifdef FSM_BRANCH_STATS_EN
   task automatic chk_cnt(input string tag, input logic [1:0] got,
                          input logic [1:0] want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 4; i++) begin
         st_v[i] = 0; a_v[i] = 0; b_v[i] = 0;
         clr_v[i] = 0; rst_v[i] = 1;
      end
      @(negedge clk);

      // u0: TIMEOUT=4, hold terminal states
      cyc(0, 0, 0, 0, 0, 1, 3'd0, "reset");
      cyc(0, 0, 0, 0, 0, 0, 3'd0, "idle_hold");
      cyc(0, 1, 1, 0, 0, 0, 3'd1, "enter_armp");
      cyc(0, 0, 0, 1, 0, 0, 3'd2, "lock_t");
      for (int i = 0; i < 10; i++)
         cyc(0, 0, 0, 0, 0, 0, 3'd2, "lock_t_hold");
      cyc(0, 0, 0, 0, 1, 0, 3'd0, "clr_lock_t");
      cyc(0, 1, 0, 0, 0, 0, 3'd3, "enter_armr");
      cyc(0, 0, 0, 1, 0, 0, 3'd3, "armr_ignores_b");
      cyc(0, 0, 0, 0, 0, 0, 3'd3, "armr_wait");
      cyc(0, 0, 0, 0, 0, 0, 3'd3, "armr_wait");
      cyc(0, 0, 0, 0, 0, 0, 3'd5, "armr_abort");
      cyc(0, 0, 0, 0, 0, 0, 3'd5, "abort_hold");
      cyc(0, 0, 0, 0, 1, 0, 3'd0, "clr_abort");
      cyc(0, 1, 0, 0, 0, 0, 3'd3, "enter_armr2");
      for (int i = 0; i < 3; i++)
         cyc(0, 0, 0, 0, 0, 0, 3'd3, "armr2_wait");
      cyc(0, 0, 1, 0, 0, 0, 3'd4, "confirm_on_expiry");
      cyc(0, 0, 0, 0, 0, 0, 3'd4, "lock_v_hold");
      cyc(0, 0, 0, 0, 0, 1, 3'd0, "rst_from_lock_v");
      cyc(0, 1, 1, 0, 1, 0, 3'd0, "clr_beats_start");
      cyc(0, 1, 1, 0, 0, 0, 3'd1, "enter_armp2");
      cyc(0, 0, 0, 0, 1, 0, 3'd0, "clr_in_armp");
      cyc(0, 1, 1, 0, 0, 0, 3'd1, "enter_armp3");
      for (int i = 0; i < 3; i++)
         cyc(0, 0, 0, 0, 0, 0, 3'd1, "armp3_wait");
      cyc(0, 0, 0, 0, 0, 0, 3'd5, "armp_abort");

      // u1: AUTO_REARM=1
      cyc(1, 0, 0, 0, 0, 1, 3'd0, "ar_reset");
      cyc(1, 1, 1, 0, 0, 0, 3'd1, "ar_armp");
      cyc(1, 0, 0, 1, 0, 0, 3'd2, "ar_lock_t");
      cyc(1, 0, 0, 0, 0, 0, 3'd0, "ar_rearm_lock");
      cyc(1, 1, 0, 0, 0, 0, 3'd3, "ar_armr");
      for (int i = 0; i < 3; i++)
         cyc(1, 0, 0, 0, 0, 0, 3'd3, "ar_armr_wait");
      cyc(1, 0, 0, 0, 0, 0, 3'd5, "ar_abort");
      cyc(1, 0, 0, 0, 0, 0, 3'd0, "ar_rearm_abort");

      // u2: TIMEOUT=0 never aborts
      cyc(2, 0, 0, 0, 0, 1, 3'd0, "t0_reset");
      cyc(2, 1, 1, 0, 0, 0, 3'd1, "t0_armp");
      for (int i = 0; i < 300; i++)
         cyc(2, 0, 0, 0, 0, 0, 3'd1, "t0_armp_hold");
      cyc(2, 0, 0, 1, 0, 0, 3'd2, "t0_lock_t");

      // u3: CNT_W=2, TIMEOUT=3, AUTO_REARM=1
      cyc(3, 0, 0, 0, 0, 1, 3'd0, "s_reset");
`ifdef FSM_BRANCH_STATS_EN
      chk_cnt("lock_cnt_rst", lc3, 2'd0);
      chk_cnt("abort_cnt_rst", ac3, 2'd0);
`endif
      for (int n = 1; n <= 5; n++) begin
         cyc(3, 1, 1, 0, 0, 0, 3'd1, "s_armp");
         cyc(3, 0, 0, 1, 0, 0, 3'd2, "s_lock_t");
         cyc(3, 0, 0, 0, 0, 0, 3'd0, "s_rearm");
`ifdef FSM_BRANCH_STATS_EN
         chk_cnt("lock_cnt_sat", lc3, (n > 3) ? 2'd3 : 2'(n));
`endif
      end
      cyc(3, 0, 0, 0, 1, 0, 3'd0, "s_clr");
`ifdef FSM_BRANCH_STATS_EN
      chk_cnt("lock_cnt_clr", lc3, 2'd3);
`endif
      cyc(3, 1, 0, 0, 0, 0, 3'd3, "s_armr");
      cyc(3, 0, 0, 0, 0, 0, 3'd3, "s_armr_wait");
      cyc(3, 0, 0, 0, 0, 0, 3'd3, "s_armr_wait");
      cyc(3, 0, 0, 0, 0, 0, 3'd5, "s_abort");
`ifdef FSM_BRANCH_STATS_EN
      chk_cnt("abort_cnt_one", ac3, 2'd1);
      chk_cnt("lock_cnt_keep", lc3, 2'd3);
`endif
      cyc(3, 0, 0, 0, 0, 1, 3'd0, "s_rst");
`ifdef FSM_BRANCH_STATS_EN
      chk_cnt("lock_cnt_rst2", lc3, 2'd0);
      chk_cnt("abort_cnt_rst2", ac3, 2'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
